mem_check_comparator: RTL and testbench

//  Multi-lane, pipelined data checker for the memory-test device. It compares read data (DIN0)

---
 rtl/mem_check_comparator_if.sv | 35 +++
 rtl/mem_check_comparator.sv | 138 +++++++++++++
 tb/tb_mem_check_comparator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_check_comparator_if.sv
// Beat request / check result bundle between the read-data path and the comparator.
interface mem_check_comparator_if #(
    parameter int p_WIDTH  = 8,
    parameter int p_LANES  = 4,
    parameter int p_ADDR_W = 16,
    parameter int p_CNT_W  = 16
);
    logic                       i_CLR;
    logic                       i_VALID;
    logic [p_ADDR_W-1:0]        i_ADDR;
    logic [p_LANES*p_WIDTH-1:0] i_DIN0;
    logic [p_LANES*p_WIDTH-1:0] i_DIN1;
    logic [p_LANES-1:0]         i_MASK;
    logic                       i_SIGNED;
    logic                       o_VALID;
    logic [p_LANES-1:0]         o_ZERO;
    logic [p_LANES-1:0]         o_EQUAL;
    logic [p_LANES-1:0]         o_LESS;
    logic                       o_ALL_EQ;
    logic                       o_FAIL;
    logic [p_ADDR_W-1:0]        o_FAIL_ADDR;
    logic [p_LANES-1:0]         o_FAIL_LANES;
    logic [p_CNT_W-1:0]         o_ERR_CNT;

    modport master (
        output i_CLR, i_VALID, i_ADDR, i_DIN0, i_DIN1, i_MASK, i_SIGNED,
        input  o_VALID, o_ZERO, o_EQUAL, o_LESS, o_ALL_EQ,
               o_FAIL, o_FAIL_ADDR, o_FAIL_LANES, o_ERR_CNT
    );
    modport slave (
        input  i_CLR, i_VALID, i_ADDR, i_DIN0, i_DIN1, i_MASK, i_SIGNED,
        output o_VALID, o_ZERO, o_EQUAL, o_LESS, o_ALL_EQ,
               o_FAIL, o_FAIL_ADDR, o_FAIL_LANES, o_ERR_CNT
    );
endinterface

// File: rtl/mem_check_comparator.sv
// Two-stage multi-lane read-data checker: per-lane zero/equal/less flags plus
// sticky fail status, saturating mismatch-beat counter and first-failure capture.
module mem_check_lane #(
    parameter int p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] din0_i,
    input  logic [p_WIDTH-1:0] din1_i,
    input  logic               mask_i,
    input  logic               signed_i,
    output logic               zero_o,
    output logic               equal_o,
    output logic               less_o
);
    logic lt_u, lt_s;

    assign lt_u = din0_i < din1_i;
    assign lt_s = $signed(din0_i) < $signed(din1_i);

    // Ignored lanes look like a clean match so they never raise a failure.
    assign zero_o  = mask_i & (din0_i == '0);
    assign equal_o = ~mask_i | (din0_i == din1_i);
    assign less_o  = mask_i & (signed_i ? lt_s : lt_u);
endmodule

module mem_check_comparator #(
    parameter int p_WIDTH  = 8,
    parameter int p_LANES  = 4,
    parameter int p_ADDR_W = 16,
    parameter int p_CNT_W  = 16
) (
    input logic                 i_CLK,
    input logic                 i_RST_N,
    mem_check_comparator_if.slave bus
);
    localparam int STAGES = 2;

    logic [p_LANES-1:0]  zero_c, eq_c, less_c;
    logic [STAGES:1]     vld_pipe_q;
    logic [p_LANES-1:0]  zero_s1_q, eq_s1_q, less_s1_q;
    logic [p_ADDR_W-1:0] addr_s1_q;

    logic [p_LANES-1:0]  zero_q, eq_q, less_q;
    logic                all_eq_q;
    logic                fail_q, fail_d;
    logic [p_ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [p_LANES-1:0]  fail_lanes_q, fail_lanes_d;
    logic [p_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                mism;

    generate
        for (genvar k = 0; k < p_LANES; k++) begin : g_lane
            mem_check_lane #(.p_WIDTH(p_WIDTH)) u_lane (
                .din0_i  (bus.i_DIN0[k*p_WIDTH +: p_WIDTH]),
                .din1_i  (bus.i_DIN1[k*p_WIDTH +: p_WIDTH]),
                .mask_i  (bus.i_MASK[k]),
                .signed_i(bus.i_SIGNED),
                .zero_o  (zero_c[k]),
                .equal_o (eq_c[k]),
                .less_o  (less_c[k])
            );
        end
    endgenerate

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            vld_pipe_q <= '0;
            zero_s1_q  <= '0;
            eq_s1_q    <= '0;
            less_s1_q  <= '0;
            addr_s1_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.i_VALID};
            if (bus.i_VALID) begin
                zero_s1_q <= zero_c;
                eq_s1_q   <= eq_c;
                less_s1_q <= less_c;
                addr_s1_q <= bus.i_ADDR;
            end
        end
    end

    // Clear takes priority, so a mismatch arriving on the clear edge is dropped.
    always_comb begin
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_lanes_d = fail_lanes_q;
        err_cnt_d    = err_cnt_q;
        mism         = vld_pipe_q[1] & ~(&eq_s1_q);
        if (bus.i_CLR) begin
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_lanes_d = '0;
            err_cnt_d    = '0;
        end else if (mism) begin
            if (err_cnt_q != '1)
                err_cnt_d = err_cnt_q + p_CNT_W'(1);
            if (!fail_q) begin
                fail_d       = 1'b1;
                fail_addr_d  = addr_s1_q;
                fail_lanes_d = ~eq_s1_q;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            zero_q       <= '0;
            eq_q         <= '0;
            less_q       <= '0;
            all_eq_q     <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_lanes_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (vld_pipe_q[1]) begin
                zero_q   <= zero_s1_q;
                eq_q     <= eq_s1_q;
                less_q   <= less_s1_q;
                all_eq_q <= &eq_s1_q;
            end
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_lanes_q <= fail_lanes_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.o_VALID      = vld_pipe_q[STAGES];
    assign bus.o_ZERO       = zero_q;
    assign bus.o_EQUAL      = eq_q;
    assign bus.o_LESS       = less_q;
    assign bus.o_ALL_EQ     = all_eq_q;
    assign bus.o_FAIL       = fail_q;
    assign bus.o_FAIL_ADDR  = fail_addr_q;
    assign bus.o_FAIL_LANES = fail_lanes_q;
    assign bus.o_ERR_CNT    = err_cnt_q;
endmodule

// File: tb/tb_mem_check_comparator.sv
// Randomized and directed check of mem_check_comparator against a beat-level model.
module tb_mem_check_comparator;
    localparam int W = 8, L = 4, AW = 16, CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk, rst_n;
    int   checks, errs;

    mem_check_comparator_if #(.p_WIDTH(W), .p_LANES(L), .p_ADDR_W(AW), .p_CNT_W(CW)) bus ();

    mem_check_comparator #(.p_WIDTH(W), .p_LANES(L), .p_ADDR_W(AW), .p_CNT_W(CW)) dut (
        .i_CLK  (clk),
        .i_RST_N(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        logic [3:0] z, e, l;
        logic [15:0] a;
    } beat_t;

    // Model state: one beat in flight plus visible outputs/status.
    beat_t       m_s1;
    bit          m_ov, m_alleq, m_fail;
    logic [3:0]  m_z, m_e, m_l, m_flanes;
    logic [15:0] m_faddr;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input bit v, input logic [15:0] a, input logic [31:0] d0,
                                      input logic [31:0] d1, input logic [3:0] mk, input bit sg);
        beat_t b;
        b.v = v; b.a = a; b.z = '0; b.e = '0; b.l = '0;
        for (int k = 0; k < L; k++) begin
            int x, y;
            x = int'(d0[8*k +: 8]);
            y = int'(d1[8*k +: 8]);
            if (sg) begin
                if (x > 127) x -= 256;
                if (y > 127) y -= 256;
            end
            if (!mk[k]) begin
                b.e[k] = 1'b1;
            end else begin
                b.z[k] = (x == 0);
                b.e[k] = (x == y);
                b.l[k] = (x < y);
            end
        end
        return b;
    endfunction

    task automatic model_reset();
        m_s1.v = 0; m_ov = 0; m_alleq = 0; m_fail = 0;
        m_z = 0; m_e = 0; m_l = 0; m_flanes = 0; m_faddr = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(bus.o_VALID), 32'(m_ov));
        chk({tag, ".zero"},  32'(bus.o_ZERO), 32'(m_z));
        chk({tag, ".equal"}, 32'(bus.o_EQUAL), 32'(m_e));
        chk({tag, ".less"},  32'(bus.o_LESS), 32'(m_l));
        chk({tag, ".alleq"}, 32'(bus.o_ALL_EQ), 32'(m_alleq));
        chk({tag, ".fail"},  32'(bus.o_FAIL), 32'(m_fail));
        chk({tag, ".faddr"}, 32'(bus.o_FAIL_ADDR), 32'(m_faddr));
        chk({tag, ".flanes"}, 32'(bus.o_FAIL_LANES), 32'(m_flanes));
        chk({tag, ".cnt"},   32'(bus.o_ERR_CNT), 32'(m_cnt));
    endtask

    // One clock: drive a beat at the falling edge, advance model at the rising edge, compare after.
    task automatic step(input string tag, input bit v, input logic [15:0] a, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [3:0] mk, input bit sg, input bit clr);
        beat_t nb, o;
        bus.i_VALID = v; bus.i_ADDR = a; bus.i_DIN0 = d0; bus.i_DIN1 = d1;
        bus.i_MASK = mk; bus.i_SIGNED = sg; bus.i_CLR = clr;
        nb = mk_beat(v, a, d0, d1, mk, sg);
        @(posedge clk);
        o = m_s1;
        m_s1 = nb;
        m_ov = o.v;
        if (o.v) begin
            m_z = o.z; m_e = o.e; m_l = o.l; m_alleq = (o.e == 4'hF);
        end
        if (clr) begin
            m_fail = 0; m_faddr = 0; m_flanes = 0; m_cnt = 0;
        end else if (o.v && o.e != 4'hF) begin
            if (m_cnt < CMAX) m_cnt++;
            if (!m_fail) begin
                m_fail = 1; m_faddr = o.a; m_flanes = ~o.e;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit clr);
        step(tag, 1'b0, 16'h0, 32'h0, 32'h0, 4'h0, 1'b0, clr);
    endtask

    initial begin
        logic [31:0] d0, d1, flip;
        checks = 0; errs = 0;
        rst_n = 1'b0;
        bus.i_CLR = 0; bus.i_VALID = 0; bus.i_ADDR = 0; bus.i_DIN0 = 0;
        bus.i_DIN1 = 0; bus.i_MASK = 0; bus.i_SIGNED = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Reset mid-stream with beats in flight
        step("rst_b1", 1, 16'h0001, 32'h1234_5678, 32'h1234_5670, 4'hF, 0, 0);
        step("rst_b2", 1, 16'h0002, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        bus.i_VALID = 0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle("rst_after", 0);

        // Equal beat
        step("t2", 1, 16'h0010, 32'h00A5_5A00, 32'h00A5_5A00, 4'hF, 0, 0);
        idle("t2_out", 0);
        chk("t2_valid", 32'(bus.o_VALID), 32'd1);
        chk("t2_equal", 32'(bus.o_EQUAL), 32'hF);
        chk("t2_zero", 32'(bus.o_ZERO), 32'h9);
        chk("t2_alleq", 32'(bus.o_ALL_EQ), 32'd1);
        chk("t2_cnt", 32'(bus.o_ERR_CNT), 32'd0);

        // Signed vs unsigned LESS on lane0
        step("t3s", 1, 16'h0020, 32'h1111_1180, 32'h1111_1101, 4'hF, 1, 0);
        step("t3u", 1, 16'h0021, 32'h1111_1180, 32'h1111_1101, 4'hF, 0, 0);
        chk("t3_less_signed", 32'(bus.o_LESS[0]), 32'd1);
        idle("t3_out", 0);
        chk("t3_less_unsigned", 32'(bus.o_LESS[0]), 32'd0);
        idle("t3_hold", 0);
        chk("t3_hold_valid", 32'(bus.o_VALID), 32'd0);
        idle("t3_clr", 1);

        // Mask and first-failure capture, back-to-back
        step("t4a", 1, 16'h0100, 32'h1122_3344, 32'h11DD_3344, 4'hB, 0, 0);
        step("t4b", 1, 16'h0101, 32'h1122_3344, 32'h1122_CC44, 4'hF, 0, 0);
        chk("t4a_fail", 32'(bus.o_FAIL), 32'd0);
        chk("t4a_alleq", 32'(bus.o_ALL_EQ), 32'd1);
        step("t4c", 1, 16'h0102, 32'h1122_3344, 32'h1122_3300, 4'hF, 0, 0);
        chk("t4b_fail", 32'(bus.o_FAIL), 32'd1);
        chk("t4b_faddr", 32'(bus.o_FAIL_ADDR), 32'h0101);
        chk("t4b_flanes", 32'(bus.o_FAIL_LANES), 32'h2);
        chk("t4b_cnt", 32'(bus.o_ERR_CNT), 32'd1);
        idle("t4_out", 0);
        chk("t4c_faddr", 32'(bus.o_FAIL_ADDR), 32'h0101);
        chk("t4c_cnt", 32'(bus.o_ERR_CNT), 32'd2);

        // Saturation of the mismatch counter
        idle("t5_clr", 1);
        for (int i = 0; i < 20; i++)
            step("t5", 1, 16'(16'h0200 + i), 32'hAAAA_AAAA, 32'h5555_5555, 4'hF, 0, 0);
        idle("t5_out", 0);
        chk("t5_sat", 32'(bus.o_ERR_CNT), 32'hF);
        idle("t5_hold", 0);

        // Clear colliding with a mismatch reaching stage 2
        step("t6m", 1, 16'h0300, 32'h0102_0304, 32'h0102_0305, 4'hF, 0, 0);
        idle("t6_clr", 1);
        chk("t6_valid", 32'(bus.o_VALID), 32'd1);
        chk("t6_fail", 32'(bus.o_FAIL), 32'd0);
        chk("t6_cnt", 32'(bus.o_ERR_CNT), 32'd0);
        step("t6n", 1, 16'h0301, 32'h0102_0304, 32'hFF02_0304, 4'hF, 0, 0);
        idle("t6_next", 0);
        chk("t6_cnt_next", 32'(bus.o_ERR_CNT), 32'd1);
        chk("t6_faddr_next", 32'(bus.o_FAIL_ADDR), 32'h0301);
        chk("t6_flanes_next", 32'(bus.o_FAIL_LANES), 32'h8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            d0 = $urandom;
            if ($urandom_range(3) == 0) d0[8*$urandom_range(3) +: 8] = 8'h00;
            flip = 32'h0;
            for (int k = 0; k < L; k++)
                if ($urandom_range(3) == 0) flip[8*k +: 8] = 8'($urandom_range(255, 1));
            d1 = ($urandom_range(2) == 0) ? 32'($urandom) : (d0 ^ flip);
            step("rnd", $urandom_range(3) != 0, 16'($urandom), d0, d1, 4'($urandom),
                 1'($urandom), $urandom_range(15) == 0);
        end
        idle("rnd_tail0", 0);
        idle("rnd_tail1", 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
